// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
// Shared helpers for the BRAM read-port arbiter.
//   safe_clog2 : index width for N items, never less than 1 bit so that a
//                single-requester build still has a legal vector width.
//   rr_next    : advances a round-robin pointer, wrapping after n-1 to 0.
//                n need not be a power of two, so a plain increment with
//                truncation would not wrap correctly.
// -----------------------------------------------------------------------------
package bram_arb_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_rd_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Scans req starting at ptr, wrapping
// at N-1 back to 0, and grants the first set bit.
// Ports:
//   req_i     [N]      request vector
//   ptr_i     [W_IDX]  highest-priority index (must be < N)
//   gnt_o     [N]      one-hot grant, all zero when nothing requests
//   gnt_idx_o [W_IDX]  binary index of the granted bit (0 when none)
//   any_o              at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W_IDX = safe_clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [W_IDX-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [W_IDX-1:0] gnt_idx_o,
  output logic             any_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] reqRot;
  logic [N-1:0] gntRot;

  // Rotate the request vector so that ptr lands on bit 0 (the doubled copy
  // makes the rotate a plain shift), isolate the lowest set bit with the
  // two's-complement trick, then rotate the one-hot back into place by
  // shifting a doubled copy left and keeping the upper half.
  always_comb begin
    reqRot = N'({req_i, req_i} >> ptr_i);
    gntRot = reqRot & (~reqRot + ONE);
    gnt_o  = N'(({gntRot, gntRot} << ptr_i) >> N);
    any_o  = |req_i;
  end

  // One-hot to binary; the loop bound is the constant N.
  always_comb begin
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) gnt_idx_o = W_IDX'(i);
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// bram_rd_arbiter
// Shares one synchronous-read BRAM port (1-cycle latency) between N_REQ
// requesters. Round-robin grant, at most one read in flight, responses are
// routed back to the requester that issued them.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_addr_valid/ready/data  per-requester address stream, data packed as
//                       requester i at [i*W_ADDR +: W_ADDR]
//   rsp_valid/ready     per-requester response handshake
//   rsp_data            shared read data, qualified by rsp_valid[i]
//   en, addr            BRAM read enable and address
//   data_i              BRAM read data, valid one cycle after en
// -----------------------------------------------------------------------------
module bram_rd_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int W_DATA = 8,
  parameter int W_ADDR = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_addr_valid,
  output logic [N_REQ-1:0]          req_addr_ready,
  input  logic [N_REQ*W_ADDR-1:0]   req_addr_data,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [W_DATA-1:0]         rsp_data,
  output logic                      en,
  output logic [W_ADDR-1:0]         addr,
  input  logic [W_DATA-1:0]         data_i
);

  localparam int W_IDX = safe_clog2(N_REQ);

  logic             rsp_pend_q, rsp_pend_d;
  logic [W_IDX-1:0] rsp_tag_q,  rsp_tag_d;
  logic [W_IDX-1:0] rr_ptr_q,   rr_ptr_d;

  logic [N_REQ-1:0] gnt;
  logic [W_IDX-1:0] gntIdx;
  logic             anyValid;
  logic             rspAccept;
  logic             canIssue;
  logic             issue;

  rr_arbiter #(
    .N     (N_REQ),
    .W_IDX (W_IDX)
  ) u_rr (
    .req_i     (req_addr_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gntIdx),
    .any_o     (anyValid)
  );

  // Response side depends only on registered state, so rsp_valid never has
  // a combinational path from any input.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = rsp_pend_q & (rsp_tag_q == W_IDX'(i));
    end
    rsp_data = data_i;
  end

  // A new read may go out when nothing is pending or the pending response is
  // being taken this very cycle. Holding rst low closes the address handshake
  // even though the cleared state would otherwise allow an issue.
  always_comb begin
    rspAccept      = rsp_pend_q & rsp_valid[rsp_tag_q] & rsp_ready[rsp_tag_q];
    canIssue       = (~rsp_pend_q | rspAccept) & rst;
    issue          = canIssue & anyValid;
    en             = issue;
    req_addr_ready = gnt & {N_REQ{canIssue}};
  end

  // Address mux driven by the one-hot grant; forced to zero when idle.
  always_comb begin
    addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] && issue) addr = req_addr_data[i*W_ADDR +: W_ADDR];
    end
  end

  // Next-state: an issue takes precedence over a plain accept because the
  // slot is immediately refilled; the pointer moves past the winner.
  always_comb begin
    rsp_pend_d = rsp_pend_q;
    rsp_tag_d  = rsp_tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (issue) begin
      rsp_pend_d = 1'b1;
      rsp_tag_d  = gntIdx;
      rr_ptr_d   = W_IDX'(rr_next(int'(gntIdx), N_REQ));
    end else if (rspAccept) begin
      rsp_pend_d = 1'b0;
    end
  end

  // State registers; reset drops any outstanding response immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pend_q <= 1'b0;
      rsp_tag_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_tag_q  <= rsp_tag_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule
